// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side feeds bytes and observes writes; the slave side is the loader.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output byte_in, byte_valid, input byte_ready, wr_en, wr_addr, wr_data);
  modport slave  (input byte_in, byte_valid, output byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian 32-bit imem writes.
// Keeps the core in reset until the whole image has been written.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         core_rst_n,
  output logic [7:0]   checksum
);
  localparam logic [31:0] CAP = 32'((64'd1 << ADDR_W) / 64'd4);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]      state, nxt;
  logic [15:0]     len, word_idx;
  logic [1:0]      byte_idx;
  logic [3:0][7:0] wbuf;
  logic            acc, can_start;

  assign bus.byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign busy           = bus.byte_ready || (state == S_CHECK) || (state == S_WRITE);
  assign acc            = bus.byte_valid && bus.byte_ready;
  assign can_start      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (can_start) nxt = S_LEN_LO;
      S_LEN_LO: if (acc) nxt = S_LEN_HI;
      S_LEN_HI: if (acc) nxt = S_CHECK;
      S_CHECK: begin
        if (len == 16'd0)              nxt = S_DONE;
        else if ({16'd0, len} > CAP)   nxt = S_ERR;
        else                           nxt = S_DATA;
      end
      S_DATA:  if (acc && byte_idx == 2'd3) nxt = S_WRITE;
      S_WRITE: nxt = (word_idx == len - 16'd1) ? S_DONE : S_DATA;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      wbuf        <= '0;
      checksum    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      core_rst_n  <= 1'b0;
    end else begin
      state <= nxt;
      // status outputs are registered from the next state so they line up with it
      bus.wr_en  <= (nxt == S_WRITE);
      done       <= (nxt == S_DONE);
      error      <= (nxt == S_ERR);
      core_rst_n <= (nxt == S_DONE);
      if (can_start) begin
        len      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        checksum <= '0;
      end
      if (acc) begin
        case (state)
          S_LEN_LO: len[7:0]  <= bus.byte_in;
          S_LEN_HI: len[15:8] <= bus.byte_in;
          S_DATA: begin
            wbuf[byte_idx] <= bus.byte_in;
            byte_idx       <= byte_idx + 2'd1;
            checksum       <= checksum + bus.byte_in;
            // last lane arrives now: latch the write while entering WRITE
            if (byte_idx == 2'd3) begin
              bus.wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              bus.wr_data <= {bus.byte_in, wbuf[2], wbuf[1], wbuf[0]};
            end
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) word_idx <= word_idx + 16'd1;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          CAP    = (1 << ADDR_W) / 4;

  typedef logic [7:0] u8;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       busy, done, error, core_rst_n;
  logic [7:0] checksum;
  int         n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
  logic [31:0] got_addr[$], got_data[$];

  imem_loader_if bus();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error), .core_rst_n(core_rst_n), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.wr_en === 1'b1) begin
    got_addr.push_back(bus.wr_addr);
    got_data.push_back(bus.wr_data);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    chk({tag, " ready1"}, 64'(bus.byte_ready), 64'd1);
    chk({tag, " busy1"}, 64'(busy), 64'd1);
    chk({tag, " crst1"}, 64'(core_rst_n), 64'd0);
  endtask

  // gap: 0 full rate, 1 one idle cycle per byte, 2 random idle cycles
  task automatic send_bytes(input u8 q[$], input int gap, input bit poke);
    for (int i = 0; i < q.size(); i++) begin
      int g, guard;
      g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = u8'($urandom);
        @(posedge clk); #1;
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = q[i];
      if (poke && i == 5) start = 1'b1;
      guard = 0;
      while (!bus.byte_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) chk("ready timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    int guard = 0;
    while (!(done || error) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("end timeout", 64'(guard < 200), 64'd1);
    lat = cyc - t0;
  endtask

  // Reference: decode the stream by its rules and compare the whole outcome.
  task automatic run_load(input string tag, input u8 q[$], input int gap, input bit poke);
    int len, expw, lat;
    bit ok;
    logic [7:0] csum = 8'd0;
    len  = int'(q[1]) * 256 + int'(q[0]);
    ok   = (len <= CAP);
    expw = ok ? len : 0;
    for (int i = 2; i < q.size(); i++) csum += q[i];
    got_addr.delete(); got_data.delete();
    do_start(tag);
    send_bytes(q, gap, poke);
    wait_end(lat);
    chk({tag, " nwr"}, 64'(got_addr.size()), 64'(expw));
    for (int i = 0; i < expw && i < got_addr.size(); i++) begin
      logic [31:0] w;
      w = {q[5+4*i], q[4+4*i], q[3+4*i], q[2+4*i]};
      chk($sformatf("%s addr%0d", tag, i), 64'(got_addr[i]), 64'(BASE + 32'(4 * i)));
      chk($sformatf("%s data%0d", tag, i), 64'(got_data[i]), 64'(w));
    end
    chk({tag, " csum"}, 64'(checksum), 64'(csum));
    chk({tag, " done"}, 64'(done), 64'(ok));
    chk({tag, " error"}, 64'(error), 64'(!ok));
    chk({tag, " crst"}, 64'(core_rst_n), 64'(ok));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " ready"}, 64'(bus.byte_ready), 64'd0);
    if (expw > 0) chk({tag, " hold"}, 64'(bus.wr_addr), 64'(BASE + 32'(4 * (expw - 1))));
    if (gap == 0) chk({tag, " lat"}, 64'(lat), 64'(3 + 5 * expw));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " wr_en"}, 64'(bus.wr_en), 64'd0);
    chk({tag, " wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, " wr_data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, " ready"}, 64'(bus.byte_ready), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
    chk({tag, " crst"}, 64'(core_rst_n), 64'd0);
    chk({tag, " csum"}, 64'(checksum), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u8 prog[$] = '{8'h02, 8'h00, 8'h93, 8'h0F, 8'h00, 8'h00, 8'h13, 8'h03, 8'hF0, 8'h00};
    u8 q[$];
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    chk("rst nwr", 64'(got_addr.size()), 64'd0);

    run_load("prog", prog, 0, 0);
    chk("prog csum lit", 64'(checksum), 64'hA8);
    if (got_data.size() == 2) begin
      logic [31:0] d1;
      d1 = got_data[1];
      chk("prog w1 lit", 64'(d1), 64'h00F00313);
    end

    q = '{8'h00, 8'h00};
    run_load("zero", q, 0, 0);
    q = '{8'h01, 8'h01};
    run_load("over", q, 0, 0);
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load("retry", q, 0, 0);
    q = '{8'hFF, 8'hFF};
    run_load("max", q, 0, 0);
    run_load("gap", prog, 1, 1);

    // reset after 6 payload bytes: first word written, second never
    got_addr.delete(); got_data.delete();
    do_start("mid");
    q = '{8'h02, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h77, 8'h88};
    send_bytes(q, 0, 0);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_reset_outs("mid");
    bus.byte_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.byte_valid = 1'b0;
    chk("mid nwr", 64'(got_addr.size()), 64'd1);
    if (got_data.size() > 0) chk("mid w0", 64'(got_data[0]), 64'h3CC35AA5);
    run_load("after", prog, 0, 0);

    // full-capacity boundary
    q.delete();
    q.push_back(u8'(CAP)); q.push_back(u8'(CAP >> 8));
    for (int i = 0; i < 4 * CAP; i++) q.push_back(u8'($urandom));
    run_load("cap", q, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int len;
      len = int'($urandom_range(1, 6));
      q.delete();
      q.push_back(u8'(len)); q.push_back(u8'(len >> 8));
      for (int i = 0; i < 4 * len; i++) q.push_back(u8'($urandom));
      run_load($sformatf("rnd%0d", r), q, (r % 2 == 0) ? 0 : 2, r[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
